// File: rtl/altair_busctl_if.sv
// altair_busctl_if: CPU-side bus and memory/I-O slave signals for altair_busctl.
interface altair_busctl_if #(
    parameter int NUM_MEM = 4,
    parameter int NUM_IO  = 2
);
    logic                  ce;
    logic                  sync;
    logic                  rd;
    logic                  wr_n;
    logic [15:0]           addr;
    logic [7:0]            odata;
    logic [7:0]            idata;
    logic [8*NUM_MEM-1:0]  mem_dout;
    logic [8*NUM_IO-1:0]   io_dout;
    logic [NUM_MEM-1:0]    mem_rd;
    logic [NUM_MEM-1:0]    mem_we;
    logic [NUM_IO-1:0]     io_rd;
    logic [NUM_IO-1:0]     io_we;
    logic                  ready;
    logic                  boot;
    logic [7:0]            status;
    logic                  wp_viol;
    logic [7:0]            wp_count;

    modport master (
        output ce, sync, rd, wr_n, addr, odata, mem_dout, io_dout,
        input  idata, mem_rd, mem_we, io_rd, io_we, ready, boot, status, wp_viol, wp_count
    );

    modport slave (
        input  ce, sync, rd, wr_n, addr, odata, mem_dout, io_dout,
        output idata, mem_rd, mem_we, io_rd, io_we, ready, boot, status, wp_viol, wp_count
    );
endinterface

// File: rtl/altair_busctl.sv
// altair_busctl: Altair-style bus controller with turnkey boot jump, region decode and I/O wait states.
// Define ALTAIR_BUSCTL_WPVIOL_EN to count writes into read-only regions (wp_viol/wp_count).
module altair_busctl #(
    parameter int                   NUM_MEM   = 4,
    parameter int                   NUM_IO    = 2,
    parameter logic [8*NUM_MEM-1:0] MEM_BASE  = {8'hFD, 8'hFB, 8'h00, 8'h00},
    parameter logic [8*NUM_MEM-1:0] MEM_MASK  = {8'hFF, 8'hFF, 8'hE0, 8'hE0},
    parameter logic [NUM_MEM-1:0]   MEM_RO    = 4'b1000,
    parameter logic [8*NUM_IO-1:0]  IO_BASE   = {8'h10, 8'h00},
    parameter logic [8*NUM_IO-1:0]  IO_MASK   = {8'hFE, 8'hFE},
    parameter logic [15:0]          BOOT_ADDR = 16'hFD00,
    parameter int                   IO_WAIT   = 2
) (
    input logic           clk,
    input logic           reset,
    altair_busctl_if.slave bus
);
    typedef enum logic [1:0] {OP, LO, HI, RUN} state_e;
    state_e               state_q, state_d;
    logic [7:0]           status_q, status_d;
    logic [3:0]           wait_q, wait_d;
    logic                 rd_q, wr_q;
    logic [NUM_MEM-1:0]   mem_oh;
    logic [NUM_IO-1:0]    io_oh;
    logic                 mem_any, io_any;
    logic [7:0]           mem_data, io_data, boot_byte;
    logic                 boot, io_cyc, rd_rise, wr_rise, io_edge;

    assign boot    = state_q != RUN;
    assign io_cyc  = status_q[6] | status_q[4];
    assign rd_rise = bus.rd & ~rd_q;
    assign wr_rise = ~bus.wr_n & ~wr_q;
    assign io_edge = (rd_rise | wr_rise) & io_cyc & io_any & ~boot;

    // Lowest-index hit wins; the one-hot vectors drive both strobes and read-data muxing.
    always_comb begin
        mem_oh   = '0;
        mem_any  = 1'b0;
        mem_data = 8'hFF;
        io_oh    = '0;
        io_any   = 1'b0;
        io_data  = 8'hFF;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (!mem_any && (bus.addr[15:8] & MEM_MASK[8*i +: 8]) == MEM_BASE[8*i +: 8]) begin
                mem_oh[i] = 1'b1;
                mem_any   = 1'b1;
                mem_data  = bus.mem_dout[8*i +: 8];
            end
        end
        for (int j = 0; j < NUM_IO; j++) begin
            if (!io_any && (bus.addr[7:0] & IO_MASK[8*j +: 8]) == IO_BASE[8*j +: 8]) begin
                io_oh[j] = 1'b1;
                io_any   = 1'b1;
                io_data  = bus.io_dout[8*j +: 8];
            end
        end
    end

    assign boot_byte   = state_q == OP ? 8'hC3 : state_q == LO ? BOOT_ADDR[7:0] : BOOT_ADDR[15:8];
    assign bus.idata   = boot ? boot_byte : io_cyc ? io_data : mem_data;
    assign bus.mem_rd  = (boot | io_cyc) ? '0 : mem_oh & {NUM_MEM{bus.rd}};
    assign bus.mem_we  = (boot | io_cyc) ? '0 : mem_oh & ~MEM_RO & {NUM_MEM{~bus.wr_n}};
    assign bus.io_rd   = (boot | ~io_cyc) ? '0 : io_oh & {NUM_IO{bus.rd}};
    assign bus.io_we   = (boot | ~io_cyc) ? '0 : io_oh & {NUM_IO{~bus.wr_n}};
    assign bus.ready   = wait_q == 4'd0;
    assign bus.boot    = boot;
    assign bus.status  = status_q;

    always_comb begin
        status_d = bus.sync ? bus.odata : status_q;
        state_d  = !rd_rise ? state_q : state_q == OP ? LO : state_q == LO ? HI : RUN;
        wait_d   = io_edge ? 4'(IO_WAIT) : (bus.ce && wait_q != 4'd0) ? wait_q - 4'd1 : wait_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= OP;
            status_q <= 8'h00;
            wait_q   <= 4'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            wait_q   <= wait_d;
            rd_q     <= bus.rd;
            wr_q     <= ~bus.wr_n;
        end
    end

`ifdef ALTAIR_BUSCTL_WPVIOL_EN
    logic       wp_hit;
    logic       wp_viol_q, wp_viol_d;
    logic [7:0] wp_count_q, wp_count_d;

    assign wp_hit = wr_rise & ~boot & ~io_cyc & (|(mem_oh & MEM_RO));

    always_comb begin
        wp_viol_d  = wp_viol_q | wp_hit;
        wp_count_d = (wp_hit && wp_count_q != 8'hFF) ? wp_count_q + 8'd1 : wp_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_viol_q  <= 1'b0;
            wp_count_q <= 8'h00;
        end else begin
            wp_viol_q  <= wp_viol_d;
            wp_count_q <= wp_count_d;
        end
    end

    assign bus.wp_viol  = wp_viol_q;
    assign bus.wp_count = wp_count_q;
`else
    assign bus.wp_viol  = 1'b0;
    assign bus.wp_count = 8'h00;
`endif
endmodule

// File: tb/tb_altair_busctl.sv
// tb_altair_busctl: directed plus randomized checks of altair_busctl against a table-driven decode model.
module tb_altair_busctl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   wp_model = 0;

    altair_busctl_if bus ();
    altair_busctl_if bus0 ();

    assign bus0.ce       = bus.ce;
    assign bus0.sync     = bus.sync;
    assign bus0.rd       = bus.rd;
    assign bus0.wr_n     = bus.wr_n;
    assign bus0.addr     = bus.addr;
    assign bus0.odata    = bus.odata;
    assign bus0.mem_dout = bus.mem_dout;
    assign bus0.io_dout  = bus.io_dout;

    altair_busctl dut (.clk(clk), .reset(reset), .bus(bus.slave));
    altair_busctl #(.IO_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    always #5 clk = ~clk;

    logic [7:0] mbase  [4] = '{8'h00, 8'h00, 8'hFB, 8'hFD};
    logic [7:0] mmask  [4] = '{8'hE0, 8'hE0, 8'hFF, 8'hFF};
    bit         mro    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] iobase [2] = '{8'h00, 8'h10};
    logic [7:0] iomask [2] = '{8'hFE, 8'hFE};
    logic [7:0] bootb  [3] = '{8'hC3, 8'h00, 8'hFD};

    function automatic int region(input logic [15:0] a);
        for (int i = 0; i < 4; i++)
            if ((a[15:8] & mmask[i]) == mbase[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wp();
`ifdef ALTAIR_BUSCTL_WPVIOL_EN
        chk("wp_viol", bus.wp_viol, wp_model > 0);
        chk("wp_count", bus.wp_count, wp_model);
`else
        chk("wp_viol", bus.wp_viol, 0);
        chk("wp_count", bus.wp_count, 0);
`endif
    endtask

    initial begin
        int r, n, guard;
        bit wr, c;
        logic [31:0] exp_rd, exp_we, exp_id;
        bus.ce = 1'b1; bus.sync = 1'b0; bus.rd = 1'b0; bus.wr_n = 1'b1;
        bus.addr = 16'h0000; bus.odata = 8'h00;
        bus.mem_dout = $urandom; bus.io_dout = 16'($urandom);
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_status", bus.status, 8'h00);
        chk("rst_boot", bus.boot, 1);
        chk("rst_ready", bus.ready, 1);
        chk("rst_idata", bus.idata, 8'hC3);
        chk_wp();

        for (int k = 0; k < 3; k++) begin
            bus.addr = 16'($urandom);
            bus.rd = 1'b1;
            #1;
            chk("boot_byte", bus.idata, bootb[k]);
            chk("boot_mem_rd", bus.mem_rd, 0);
            chk("boot_flag", bus.boot, 1);
            step();
            bus.rd = 1'b0;
            step();
        end
        chk("boot_done", bus.boot, 0);

        bus.addr = 16'h1234; bus.mem_dout = $urandom; bus.rd = 1'b1;
        #1;
        chk("mem_rd_1234", bus.mem_rd, 4'b0001);
        chk("idata_1234", bus.idata, bus.mem_dout[7:0]);
        step(); bus.rd = 1'b0; step();
        bus.addr = 16'h8000; bus.rd = 1'b1;
        #1;
        chk("mem_rd_8000", bus.mem_rd, 0);
        chk("idata_8000", bus.idata, 8'hFF);
        step(); bus.rd = 1'b0; step();

        for (int k = 0; k < 40; k++) begin
            bus.addr = (k % 4 == 0) ? {8'hFD, 8'($urandom)} : 16'($urandom);
            bus.mem_dout = $urandom;
            wr = 1'($urandom_range(0, 1));
            if (wr) bus.wr_n = 1'b0; else bus.rd = 1'b1;
            #1;
            r = region(bus.addr);
            exp_rd = (!wr && r >= 0) ? 32'(1 << r) : 0;
            exp_we = (wr && r >= 0 && !mro[r]) ? 32'(1 << r) : 0;
            exp_id = (r >= 0) ? 32'(bus.mem_dout[8*r +: 8]) : 32'hFF;
            chk("rnd_mem_rd", bus.mem_rd, exp_rd);
            chk("rnd_mem_we", bus.mem_we, exp_we);
            chk("rnd_idata", bus.idata, exp_id);
            chk("rnd_io_rd", bus.io_rd, 0);
            step();
            if (wr && r >= 0 && mro[r] && wp_model < 255) wp_model++;
            bus.rd = 1'b0; bus.wr_n = 1'b1;
            step();
            chk("rnd_ready", bus.ready, 1);
        end
        chk_wp();

        bus.addr = 16'hFD10; bus.wr_n = 1'b0;
        #1;
        chk("ro_mem_we", bus.mem_we, 0);
        step(); bus.wr_n = 1'b1; step();
        if (wp_model < 255) wp_model++;
        chk_wp();
        for (int k = 0; k < 300; k++) begin
            bus.wr_n = 1'b0; step(); bus.wr_n = 1'b1; step();
            if (wp_model < 255) wp_model++;
        end
        chk_wp();

        bus.odata = 8'h40; bus.sync = 1'b1;
        #1;
        chk("status_same_cycle", bus.status, 8'h00);
        step(); bus.sync = 1'b0;
        #1;
        chk("status_io_rd", bus.status, 8'h40);
        bus.addr = 16'h1111; bus.io_dout = 16'($urandom); bus.rd = 1'b1;
        #1;
        chk("io_rd_1111", bus.io_rd, 2'b10);
        chk("io_mem_rd", bus.mem_rd, 0);
        chk("io_idata", bus.idata, bus.io_dout[15:8]);
        chk("io_ready_pre", bus.ready, 1);
        step();
        bus.rd = 1'b0;
        chk("io_ready_low", bus.ready, 0);
        chk("io_ready_nowait", bus0.ready, 1);
        n = 0; guard = 0;
        while (bus.ready !== 1'b1 && guard < 100) begin
            bus.ce = 1'($urandom_range(0, 1));
            c = bus.ce;
            step();
            if (c) n++;
            guard++;
        end
        bus.ce = 1'b1;
        chk("wait_bound", guard < 100, 1);
        chk("wait_ce_cycles", n, 2);

        bus.rd = 1'b1; step(); bus.rd = 1'b0; step();
        chk("reload_pre", bus.ready, 0);
        bus.rd = 1'b1; step(); bus.rd = 1'b0; step();
        chk("reload_hold", bus.ready, 0);
        chk("reload_nowait", bus0.ready, 1);
        step();
        chk("reload_done", bus.ready, 1);

        bus.addr = 16'h0020; bus.rd = 1'b1;
        #1;
        chk("io_unmapped_rd", bus.io_rd, 0);
        chk("io_unmapped_idata", bus.idata, 8'hFF);
        step();
        chk("io_unmapped_ready", bus.ready, 1);
        bus.rd = 1'b0; step();

        bus.odata = 8'h10; bus.sync = 1'b1; step(); bus.sync = 1'b0;
        bus.addr = 16'h0011; bus.wr_n = 1'b0;
        #1;
        chk("io_we_11", bus.io_we, 2'b10);
        chk("io_we_rd", bus.io_rd, 0);
        step();
        chk("io_we_wait", bus.ready, 0);
        bus.wr_n = 1'b1;
        step(); step();
        chk("io_we_done", bus.ready, 1);

        bus.odata = 8'h40; bus.sync = 1'b1; step(); bus.sync = 1'b0;
        bus.addr = 16'h1111; bus.rd = 1'b1; step(); bus.rd = 1'b0;
        chk("rst_wait_pre", bus.ready, 0);
        reset = 1'b1; step();
        chk("rst_wait_ready", bus.ready, 1);
        chk("rst_wait_boot", bus.boot, 1);
        chk("rst_wait_status", bus.status, 8'h00);
        reset = 1'b0; step();

        for (int k = 0; k < 2; k++) begin
            bus.rd = 1'b1; #1;
            chk("reboot_byte", bus.idata, bootb[k]);
            step(); bus.rd = 1'b0; step();
        end
        reset = 1'b1; step(); reset = 1'b0; step();
        bus.addr = 16'h1234; bus.rd = 1'b1; #1;
        chk("reboot_restart", bus.idata, 8'hC3);
        chk("reboot_mem_rd", bus.mem_rd, 0);
        step(); bus.rd = 1'b0; step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/altair_busctl.md
ALTAIR_BUSCTL -- requirements
Module: altair_busctl

Interface
REQ-001 The block SHALL have parameter NUM_MEM, default 4, giving the number of memory regions (1..8).
REQ-002 The block SHALL have parameter NUM_IO, default 2, giving the number of I/O channels (1..8).
REQ-003 The block SHALL have parameters MEM_BASE and MEM_MASK (8*NUM_MEM bits each), default {8'hFD,8'hFB,8'h00,8'h00} and {8'hFF,8'hFF,8'hE0,8'hE0}, giving the per-region addr[15:8] base and mask, with region 0 in the low byte.
REQ-004 The block SHALL have parameter MEM_RO (NUM_MEM bits), default 4'b1000, where a set bit makes that region read-only.
REQ-005 The block SHALL have parameters IO_BASE and IO_MASK (8*NUM_IO bits each), default {8'h10,8'h00} and {8'hFE,8'hFE}, giving the per-channel port address base and mask.
REQ-006 The block SHALL have parameters BOOT_ADDR, default 16'hFD00, the turnkey jump target, and IO_WAIT, default 2, the I/O wait-state count (0..15).
REQ-007 Ports: clk in 1, the system clock.
REQ-008 Ports: reset in 1, synchronous active-high reset.
REQ-009 Ports: ce in 1 (CPU clock enable); sync in 1 (status strobe); rd in 1 (read strobe); wr_n in 1 (write strobe, active low).
REQ-010 Ports: addr in 16 (CPU address); odata in 8 (CPU data out); idata out 8 (CPU data in).
REQ-011 Ports: mem_dout in 8*NUM_MEM and io_dout in 8*NUM_IO (slave read data); mem_rd, mem_we out NUM_MEM; io_rd, io_we out NUM_IO.
REQ-012 Ports: ready out 1 (CPU wait request when 0); boot out 1 (turnkey active); status out 8 (latched status byte); wp_viol out 1; wp_count out 8.

Function
REQ-013 The block SHALL load status with odata on every clk where sync=1, and SHALL use the registered value for decode, so a same-cycle sync affects the next cycle only.
REQ-014 The block SHALL treat a cycle as I/O read when status[6]=1, as I/O write when status[4]=1, and otherwise as memory.
REQ-015 The memory hit for region i SHALL be (addr[15:8] & MEM_MASK[i]) == MEM_BASE[i], the lowest hit index winning; the I/O hit for channel j SHALL be (addr[7:0] & IO_MASK[j]) == IO_BASE[j], the lowest index winning.
REQ-016 The strobe outputs SHALL be one-hot or zero: mem_rd[i]=rd, mem_we[i]=~wr_n unless MEM_RO[i], io_rd[j]=rd, io_we[j]=~wr_n, for the winning hit only, and SHALL be all zero while boot=1.
REQ-017 idata SHALL be combinational: the boot byte while boot=1, else the winning slave's data, else 8'hFF for unmapped addresses.
REQ-018 The boot FSM SHALL have states OP, LO, HI, RUN, and SHALL reset to OP; boot SHALL be 1 in OP, LO and HI.
REQ-019 The boot bytes SHALL be OP=8'hC3, LO=BOOT_ADDR[7:0], HI=BOOT_ADDR[15:8], independent of addr.
REQ-020 The boot FSM SHALL advance OP->LO->HI->RUN on each rd rising edge (rd=1 and registered rd=0), and SHALL remain in RUN until reset.
REQ-021 On the rising edge of rd or of ~wr_n with an I/O hit and boot=0, the wait counter SHALL load IO_WAIT.
REQ-022 The wait counter SHALL decrement on each clk with ce=1 while nonzero; ready SHALL be 1 exactly when the counter is 0, and IO_WAIT=0 SHALL never drop ready.
REQ-023 A strobe edge SHALL reload the counter even when it is nonzero; memory accesses SHALL never drop ready.
REQ-024 A reset asserted mid-boot or mid-wait SHALL return the FSM to OP and the counter to 0 on the next clk.

Reset
REQ-025 Reset SHALL set status=8'h00, FSM=OP (boot=1), wait counter=0 (ready=1), registered strobes=0, wp_viol=0 and wp_count=0.

Configuration
REQ-026 With ALTAIR_BUSCTL_WPVIOL_EN defined, each ~wr_n rising edge that hits a MEM_RO region outside boot SHALL set sticky wp_viol and increment wp_count, saturating at 8'hFF.
REQ-027 Without ALTAIR_BUSCTL_WPVIOL_EN, wp_viol and wp_count SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-028 Reset, then three rd pulses at any addresses -> idata 8'hC3, 8'h00, 8'hFD in turn, mem_rd=0 throughout; boot=0 after the third pulse.
REQ-029 After boot, memory read at 16'h1234 -> mem_rd=4'b0001 and idata=mem_dout[7:0]; read at 16'h8000 -> mem_rd=0 and idata=8'hFF.
REQ-030 Write to 16'hFD10 -> mem_we=0; with the macro defined, wp_viol=1 and wp_count=1; 300 such writes -> wp_count=8'hFF.
REQ-031 sync with odata=8'h40, then rd at addr 16'h1111 -> io_rd=2'b10 and ready low for exactly 2 ce=1 cycles; with IO_WAIT=0, ready stays 1.
REQ-032 Reset asserted after the second boot read -> the next read returns 8'hC3; reset during a wait -> ready=1 on the next clk.
